// File: rtl/detect_event_counter_pkg.sv
// Shared constants and types for the detect event counter.
// Holds BCD limits, digit count and the LED stretch-counter width.
package detect_event_counter_pkg;

  localparam logic [3:0] BCD_MAX_DIGIT = 4'd9;
  localparam int         NUM_DIGITS    = 4;
  localparam int         STRETCH_W     = 4;

  typedef logic [3:0]           bcd_t;
  typedef logic [STRETCH_W-1:0] stretch_t;

  function automatic logic bcd_is_max(input bcd_t d);
    return d == BCD_MAX_DIGIT;
  endfunction

endpackage

// File: rtl/detect_event_counter_if.sv
// Detect/count bundle between the board logic and the counter.
// The master drives detect and control; the slave returns count state.
interface detect_event_counter_if;
  import detect_event_counter_pkg::*;

  logic        det_in;
  logic        clr;
  logic        hold;
  logic [15:0] count_bcd;
  logic        overflow;
  logic        event_pulse;
  logic        det_led;

  modport master (
    output det_in,
    output clr,
    output hold,
    input  count_bcd,
    input  overflow,
    input  event_pulse,
    input  det_led
  );

  modport slave (
    input  det_in,
    input  clr,
    input  hold,
    output count_bcd,
    output overflow,
    output event_pulse,
    output det_led
  );

endinterface

// File: rtl/detect_event_counter_bcd_digit.sv
// One BCD digit of the event counter: 0..9 with carry in/out.
// Carry-out is combinational so the chain settles within one cycle.
module bcd_digit
  import detect_event_counter_pkg::*;
(
  input  logic clk_out,
  input  logic rst,
  input  logic clr_i,
  input  logic cin_i,
  output bcd_t digit_o,
  output logic cout_o
);

  bcd_t digit_q;
  bcd_t digit_d;

  always_comb begin
    digit_d = digit_q;
    if (clr_i) begin
      digit_d = '0;
    end else if (cin_i) begin
      digit_d = bcd_is_max(digit_q) ? '0 : digit_q + 4'd1;
    end
  end

  always_ff @(posedge clk_out or posedge rst) begin
    if (rst) begin
      digit_q <= '0;
    end else begin
      digit_q <= digit_d;
    end
  end

  assign digit_o = digit_q;
  assign cout_o  = cin_i & bcd_is_max(digit_q);

endmodule

// File: rtl/detect_event_counter.sv
// Counts rising edges of the sequence-detect flag as four BCD digits,
// with sticky overflow, an accept strobe and a stretched LED output.
module detect_event_counter
  import detect_event_counter_pkg::*;
#(
  parameter bit SATURATE = 1'b0,
  parameter int STRETCH  = 4
) (
  input logic                    clk_out,
  input logic                    rst,
  detect_event_counter_if.slave  bus
);

  localparam stretch_t STRETCH_LD = STRETCH_W'(STRETCH);

  logic                det_d_q;
  logic                rise;
  logic                accept;
  logic                all_max;
  logic                inc_en;
  logic                ovf_set;
  logic [NUM_DIGITS:0] carry;
  bcd_t                digits [NUM_DIGITS];
  logic [15:0]         count_w;

  logic                ovf_q;
  logic                ovf_d;
  logic                pulse_q;
  logic                led_q;
  logic                led_d;
  stretch_t            str_q;
  stretch_t            str_d;

  assign rise   = bus.det_in & ~det_d_q;
  assign accept = rise & ~bus.hold & ~bus.clr;

  always_comb begin
    all_max = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      all_max = all_max & bcd_is_max(digits[i]);
    end
  end

  // Saturating build blocks the carry chain entirely at 9999.
  assign inc_en   = accept & ~(SATURATE & all_max);
  assign carry[0] = inc_en;

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_digit
    bcd_digit u_digit (
      .clk_out (clk_out),
      .rst     (rst),
      .clr_i   (bus.clr),
      .cin_i   (carry[g]),
      .digit_o (digits[g]),
      .cout_o  (carry[g+1])
    );
    assign count_w[g*4 +: 4] = digits[g];
  end

  assign ovf_set = SATURATE ? (accept & all_max) : carry[NUM_DIGITS];

  always_comb begin
    ovf_d = ovf_q;
    if (bus.clr) begin
      ovf_d = 1'b0;
    end else if (ovf_set) begin
      ovf_d = 1'b1;
    end
  end

  // LED stays lit while the reloaded counter has more than one tick left.
  always_comb begin
    str_d = str_q;
    if (rise) begin
      str_d = STRETCH_LD;
    end else if (str_q != '0) begin
      str_d = str_q - 1'b1;
    end
    led_d = rise | (str_q > stretch_t'(1));
  end

  always_ff @(posedge clk_out or posedge rst) begin
    if (rst) begin
      det_d_q <= 1'b0;
      ovf_q   <= 1'b0;
      pulse_q <= 1'b0;
      led_q   <= 1'b0;
      str_q   <= '0;
    end else begin
      det_d_q <= bus.det_in;
      ovf_q   <= ovf_d;
      pulse_q <= accept;
      led_q   <= led_d;
      str_q   <= str_d;
    end
  end

  assign bus.count_bcd   = count_w;
  assign bus.overflow    = ovf_q;
  assign bus.event_pulse = pulse_q;
  assign bus.det_led     = led_q;

endmodule

// File: tb/tb_detect_event_counter.sv
// Directed bench for detect_event_counter, wrap and saturate builds.
// Both instances see identical stimulus from one initial block.
module tb_detect_event_counter;

  logic clk;
  logic rst;
  logic det;
  logic clr;
  logic hold;

  int nvec;
  int nfail;
  int npulse;
  logic [9:0] led_pat;

  detect_event_counter_if bw();
  detect_event_counter_if bs();

  assign bw.det_in = det;
  assign bw.clr    = clr;
  assign bw.hold   = hold;
  assign bs.det_in = det;
  assign bs.clr    = clr;
  assign bs.hold   = hold;

  detect_event_counter #(.SATURATE(1'b0), .STRETCH(4)) u_wrap (
    .clk_out (clk),
    .rst     (rst),
    .bus     (bw.slave)
  );

  detect_event_counter #(.SATURATE(1'b1), .STRETCH(4)) u_sat (
    .clk_out (clk),
    .rst     (rst),
    .bus     (bs.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs,
                     input logic [15:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic ev();
    det = 1'b1;
    step();
    if (bw.event_pulse) npulse++;
    det = 1'b0;
    step();
  endtask

  initial begin
    nvec = 0; nfail = 0; npulse = 0;
    rst = 1'b1; det = 1'b0; clr = 1'b0; hold = 1'b0;
    #1;
    chk("rst_count", bw.count_bcd, 16'h0000);
    chk("rst_ovf", {15'd0, bw.overflow}, 16'd0);
    chk("rst_pulse", {15'd0, bw.event_pulse}, 16'd0);
    chk("rst_led", {15'd0, bw.det_led}, 16'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    step();

    // five single-cycle detects
    for (int i = 0; i < 5; i++) begin
      ev();
      step();
    end
    chk("five_count", bw.count_bcd, 16'h0005);
    chk("five_pulses", 16'(npulse), 16'd5);
    chk("five_ovf", {15'd0, bw.overflow}, 16'd0);
    repeat (5) step();
    chk("led_idle", {15'd0, bw.det_led}, 16'd0);

    // long high detect: one count, LED lit for STRETCH cycles
    npulse = 0;
    det = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      led_pat[i] = bw.det_led;
      if (bw.event_pulse) npulse++;
    end
    det = 1'b0;
    step();
    chk("long_count", bw.count_bcd, 16'h0006);
    chk("long_pulses", 16'(npulse), 16'd1);
    chk("long_led", {6'd0, led_pat}, 16'h000F);

    // hold discards events, LED still retriggers
    repeat (5) step();
    hold = 1'b1;
    det = 1'b1;
    step();
    chk("hold_led_a", {15'd0, bw.det_led}, 16'd1);
    det = 1'b0;
    repeat (3) step();
    det = 1'b1;
    step();
    chk("hold_led_b", {15'd0, bw.det_led}, 16'd1);
    det = 1'b0;
    step();
    det = 1'b1;
    step();
    chk("hold_led_c", {15'd0, bw.det_led}, 16'd1);
    hold = 1'b0;
    step();
    chk("hold_rel_pulse", {15'd0, bw.event_pulse}, 16'd0);
    det = 1'b0;
    step();
    chk("hold_count", bw.count_bcd, 16'h0006);

    // clr beats a simultaneous event
    repeat (36) ev();
    chk("pre_clr", bw.count_bcd, 16'h0042);
    repeat (5) step();
    det = 1'b1;
    clr = 1'b1;
    step();
    chk("clr_count", bw.count_bcd, 16'h0000);
    chk("clr_ovf", {15'd0, bw.overflow}, 16'd0);
    chk("clr_pulse", {15'd0, bw.event_pulse}, 16'd0);
    chk("clr_led", {15'd0, bw.det_led}, 16'd1);
    clr = 1'b0;
    det = 1'b0;
    step();

    // async reset mid-stretch
    repeat (7) ev();
    chk("pre_rst", bw.count_bcd, 16'h0007);
    chk("pre_rst_led", {15'd0, bw.det_led}, 16'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_count", bw.count_bcd, 16'h0000);
    chk("arst_led", {15'd0, bw.det_led}, 16'd0);
    chk("arst_pulse", {15'd0, bw.event_pulse}, 16'd0);
    @(negedge clk);
    det = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    step();
    chk("rel_count", bw.count_bcd, 16'h0001);
    chk("rel_pulse", {15'd0, bw.event_pulse}, 16'd1);
    det = 1'b0;
    step();

    // carry chain, wrap and saturate
    repeat (998) ev();
    chk("cnt_0999", bw.count_bcd, 16'h0999);
    ev();
    chk("cnt_1000", bw.count_bcd, 16'h1000);
    repeat (8999) ev();
    chk("cnt_9999", bw.count_bcd, 16'h9999);
    chk("sat_9999", bs.count_bcd, 16'h9999);
    chk("ovf_before", {15'd0, bw.overflow}, 16'd0);
    det = 1'b1;
    step();
    chk("wrap_count", bw.count_bcd, 16'h0000);
    chk("wrap_ovf", {15'd0, bw.overflow}, 16'd1);
    chk("wrap_pulse", {15'd0, bw.event_pulse}, 16'd1);
    chk("sat_count", bs.count_bcd, 16'h9999);
    chk("sat_ovf", {15'd0, bs.overflow}, 16'd1);
    chk("sat_pulse", {15'd0, bs.event_pulse}, 16'd1);
    det = 1'b0;
    step();
    ev();
    chk("sticky_count", bw.count_bcd, 16'h0001);
    chk("sticky_ovf", {15'd0, bw.overflow}, 16'd1);
    chk("sat_sticky", {15'd0, bs.overflow}, 16'd1);
    clr = 1'b1;
    step();
    clr = 1'b0;
    chk("clr_ovf_w", {15'd0, bw.overflow}, 16'd0);
    chk("clr_ovf_s", {15'd0, bs.overflow}, 16'd0);
    chk("clr_cnt_s", bs.count_bcd, 16'h0000);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
